// File: rtl/spi_command_controller.sv
// spi_command_controller: oversamples a mode-0 SPI bus in the core clock
// domain and turns frames into memory write/read request pulses. Frames are
// {rw, code, address} followed by data words; words keep bursting with
// address auto-increment while CS_n stays low.
module spi_command_controller #(
  parameter int CODE_BIT_WIDTH          = 4,
  parameter int START_ADDRESS_BIT_WIDTH = 14,
  parameter int MESSAGE_BIT_WIDTH       = 32,
  parameter int SYNC_STAGES             = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               spi_cs_n,
  input  logic                               spi_sclk,
  input  logic                               spi_mosi,
  output logic                               spi_miso,
  output logic                               program_memory_new,
  output logic                               read_memory_sync,
  output logic [CODE_BIT_WIDTH-1:0]          memory_code,
  output logic [START_ADDRESS_BIT_WIDTH-1:0] spi_address,
  output logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_in,
  input  logic [MESSAGE_BIT_WIDTH-1:0]       spi_data_out
);

  localparam int CW     = CODE_BIT_WIDTH;
  localparam int AW     = START_ADDRESS_BIT_WIDTH;
  localparam int MW     = MESSAGE_BIT_WIDTH;
  localparam int HDR_W  = 1 + CW + AW;
  localparam int MAX_W  = (HDR_W > MW) ? HDR_W : MW;
  localparam int CNT_W  = $clog2(MAX_W + 1);
  localparam int SYNC_N = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  localparam logic [CNT_W-1:0] HDR_LAST = CNT_W'(HDR_W - 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MW - 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    HEADER     = 2'd1,
    WRITE_DATA = 2'd2,
    READ_DATA  = 2'd3
  } state_t;

  state_t state, state_nx;

  logic [SYNC_N-1:0] cs_sync, sclk_sync, mosi_sync;
  logic              cs_d, sclk_d;
  logic              cs_s, sclk_s, mosi_s;
  logic              cs_rise, cs_fall, sclk_rise, sclk_fall;

  logic [CNT_W-1:0]  bit_cnt;
  logic [HDR_W-2:0]  hdr_sr;   // header bits seen so far (last bit comes from mosi_s)
  logic [HDR_W-1:0]  hdr_nx;
  logic [MW-2:0]     data_sr;
  logic [MW-1:0]     out_sr;
  logic              rd_cap;   // spi_data_out is valid this cycle
  logic              hdr_last, wr_last, rd_last;

  assign cs_s   = cs_sync[SYNC_N-1];
  assign sclk_s = sclk_sync[SYNC_N-1];
  assign mosi_s = mosi_sync[SYNC_N-1];

  assign cs_rise   =  cs_s   & ~cs_d;
  assign cs_fall   = ~cs_s   &  cs_d;
  assign sclk_rise =  sclk_s & ~sclk_d;
  assign sclk_fall = ~sclk_s &  sclk_d;

  assign hdr_nx = {hdr_sr, mosi_s};

  // MISO only drives data while a read word is being shifted out
  assign spi_miso = (state == READ_DATA) & out_sr[MW-1];

  // Input synchronisers plus one history sample for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_sync   <= '0;
      sclk_sync <= '0;
      mosi_sync <= '0;
      cs_d      <= 1'b0;
      sclk_d    <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[SYNC_N-2:0], spi_cs_n};
      sclk_sync <= {sclk_sync[SYNC_N-2:0], spi_sclk};
      mosi_sync <= {mosi_sync[SYNC_N-2:0], spi_mosi};
      cs_d      <= cs_s;
      sclk_d    <= sclk_s;
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next state and end-of-field strobes; a CS_n rise outranks everything
  always_comb begin
    state_nx = state;
    hdr_last = 1'b0;
    wr_last  = 1'b0;
    rd_last  = 1'b0;
    if (state != IDLE && cs_rise) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:       if (cs_fall) state_nx = HEADER;
        HEADER: begin
          if (sclk_rise && bit_cnt == HDR_LAST) begin
            hdr_last = 1'b1;
            state_nx = hdr_nx[HDR_W-1] ? WRITE_DATA : READ_DATA;
          end
        end
        WRITE_DATA: wr_last = sclk_rise && (bit_cnt == MSG_LAST);
        READ_DATA:  rd_last = sclk_rise && (bit_cnt == MSG_LAST);
        default:    state_nx = IDLE;
      endcase
    end
  end

  // Datapath: shift registers, counters, request pulses and address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt            <= '0;
      hdr_sr             <= '0;
      data_sr            <= '0;
      out_sr             <= '0;
      rd_cap             <= 1'b0;
      program_memory_new <= 1'b0;
      read_memory_sync   <= 1'b0;
      memory_code        <= '0;
      spi_address        <= '0;
      spi_data_in        <= '0;
    end else begin
      program_memory_new <= wr_last;
      read_memory_sync   <= rd_last | (hdr_last & ~hdr_nx[HDR_W-1]);
      rd_cap             <= read_memory_sync;

      if (state_nx != state || wr_last || rd_last) bit_cnt <= '0;
      else if (sclk_rise && state != IDLE)         bit_cnt <= bit_cnt + 1'b1;

      if (state == HEADER && sclk_rise)     hdr_sr  <= hdr_nx[HDR_W-2:0];
      if (state == WRITE_DATA && sclk_rise) data_sr <= {data_sr[MW-3:0], mosi_s};

      if (wr_last) spi_data_in <= {data_sr, mosi_s};

      // Header sets the base address; reads bump it at the word boundary so the
      // next read pulse carries it, writes bump it the cycle after their pulse.
      if (hdr_last) begin
        memory_code <= hdr_nx[CW+AW-1:AW];
        spi_address <= hdr_nx[AW-1:0];
      end else if (rd_last || program_memory_new) begin
        spi_address <= spi_address + 1'b1;
      end

      // The first falling edge after a load belongs to the previous bit, so
      // shifting only starts once the current word has seen a rising edge.
      if (rd_cap)
        out_sr <= spi_data_out;
      else if (state == READ_DATA && sclk_fall && bit_cnt != '0)
        out_sr <= {out_sr[MW-2:0], 1'b0};
    end
  end

endmodule

// File: tb/tb_spi_command_controller.sv
// Bench for spi_command_controller: a bit-banged SPI master drives frames, a
// simple memory model answers reads, and a scoreboard checks every pulse.
module tb_spi_command_controller;

  localparam int HALF = 8;  // SCLK half period in clk cycles

  logic        clk = 1'b0;
  logic        rst_n;
  logic        spi_cs_n, spi_sclk, spi_mosi, spi_miso;
  logic        program_memory_new, read_memory_sync;
  logic [3:0]  memory_code;
  logic [13:0] spi_address;
  logic [31:0] spi_data_in;
  logic [31:0] spi_data_out = '0;

  int vectors     = 0;
  int miscompares = 0;
  int rd_mode     = 0;

  typedef struct packed {
    logic        wr;
    logic [3:0]  code;
    logic [13:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  spi_command_controller dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .spi_cs_n           (spi_cs_n),
    .spi_sclk           (spi_sclk),
    .spi_mosi           (spi_mosi),
    .spi_miso           (spi_miso),
    .program_memory_new (program_memory_new),
    .read_memory_sync   (read_memory_sync),
    .memory_code        (memory_code),
    .spi_address        (spi_address),
    .spi_data_in        (spi_data_in),
    .spi_data_out       (spi_data_out)
  );

  always #5 clk = ~clk;

  // Memory model: read data valid one clk after the request pulse
  always @(posedge clk) begin
    if (read_memory_sync)
      spi_data_out <= (rd_mode == 0) ? 32'hA5A5_0F0F : (32'h0000_1000 + {18'b0, spi_address});
  end

  // Monitor: every pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (rst_n && (program_memory_new || read_memory_sync)) begin
      exp_t e;
      vectors++;
      if (program_memory_new && read_memory_sync) begin
        miscompares++;
        $display("FAIL excl: both pulses high addr=%h", spi_address);
      end else if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected: wr=%0b code=%h addr=%h data=%h, expected no pulse",
                 program_memory_new, memory_code, spi_address, spi_data_in);
      end else begin
        e = exp_q.pop_front();
        if (program_memory_new != e.wr || memory_code != e.code || spi_address != e.addr ||
            (e.wr && spi_data_in != e.data)) begin
          miscompares++;
          $display("FAIL pulse: got wr=%0b code=%h addr=%h data=%h, expected wr=%0b code=%h addr=%h data=%h",
                   program_memory_new, memory_code, spi_address, spi_data_in,
                   e.wr, e.code, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic wr, input logic [3:0] code, input logic [13:0] addr,
                      input logic [31:0] data);
    exp_t e;
    e.wr = wr; e.code = code; e.addr = addr; e.data = data;
    exp_q.push_back(e);
  endtask

  // One SCLK period; MISO sampled just before the rising edge
  task automatic xfer(input logic b, input bit cs_last, output logic m);
    spi_mosi = b;
    wait_clks(HALF);
    m = spi_miso;
    spi_sclk = 1'b1;
    if (cs_last) spi_cs_n = 1'b1;
    wait_clks(HALF);
    spi_sclk = 1'b0;
  endtask

  task automatic begin_frame();
    spi_cs_n = 1'b0;
    wait_clks(HALF);
  endtask

  task automatic end_frame();
    wait_clks(4);
    spi_cs_n = 1'b1;
    wait_clks(12);
  endtask

  task automatic send_hdr(input logic rw, input logic [3:0] code, input logic [13:0] addr);
    logic [18:0] h;
    logic        m;
    h = {rw, code, addr};
    for (int i = 18; i >= 0; i--) xfer(h[i], 1'b0, m);
  endtask

  task automatic send_bits(input logic [31:0] w, input int n, input bit cs_last,
                           output logic [31:0] rd);
    logic m;
    rd = '0;
    for (int i = 31; i >= 32 - n; i--) begin
      xfer(w[i], cs_last && (i == 32 - n), m);
      rd[i] = m;
    end
  endtask

  initial begin
    logic [31:0] rd;
    rst_n = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0;
    wait_clks(3);
    chk("rst_wr_pulse", {31'b0, program_memory_new}, 32'h0);
    chk("rst_rd_pulse", {31'b0, read_memory_sync}, 32'h0);
    chk("rst_miso",     {31'b0, spi_miso}, 32'h0);
    chk("rst_code",     {28'b0, memory_code}, 32'h0);
    chk("rst_addr",     {18'b0, spi_address}, 32'h0);
    chk("rst_data",     spi_data_in, 32'h0);
    rst_n = 1'b1;
    wait_clks(5);

    // Single write
    push(1'b1, 4'h3, 14'h0012, 32'hDEAD_BEEF);
    begin_frame(); send_hdr(1'b1, 4'h3, 14'h0012);
    send_bits(32'hDEAD_BEEF, 32, 1'b0, rd);
    end_frame();

    // Burst write across the address wrap
    push(1'b1, 4'h2, 14'h3FFE, 32'h1);
    push(1'b1, 4'h2, 14'h3FFF, 32'h2);
    push(1'b1, 4'h2, 14'h0000, 32'h3);
    begin_frame(); send_hdr(1'b1, 4'h2, 14'h3FFE);
    send_bits(32'h1, 32, 1'b0, rd);
    send_bits(32'h2, 32, 1'b0, rd);
    send_bits(32'h3, 32, 1'b0, rd);
    end_frame();

    // Single read; CS_n rises with the last rising edge so no prefetch pulse
    rd_mode = 0;
    push(1'b0, 4'h5, 14'h0100, 32'h0);
    begin_frame(); send_hdr(1'b0, 4'h5, 14'h0100);
    send_bits(32'h0, 32, 1'b1, rd);
    wait_clks(12);
    chk("rd1_miso", rd, 32'hA5A5_0F0F);
    chk("rd1_idle_miso", {31'b0, spi_miso}, 32'h0);

    // Burst read of two words
    rd_mode = 1;
    push(1'b0, 4'hA, 14'h0200, 32'h0);
    push(1'b0, 4'hA, 14'h0201, 32'h0);
    begin_frame(); send_hdr(1'b0, 4'hA, 14'h0200);
    send_bits(32'h0, 32, 1'b0, rd);
    chk("rdb_w0", rd, 32'h0000_1200);
    send_bits(32'h0, 32, 1'b1, rd);
    chk("rdb_w1", rd, 32'h0000_1201);
    wait_clks(12);

    // Abort after 20 data bits, then a full frame
    begin_frame(); send_hdr(1'b1, 4'h6, 14'h0055);
    send_bits(32'hFFFF_FFFF, 20, 1'b0, rd);
    end_frame();
    chk("abort_data_held", spi_data_in, 32'h0000_0003);
    push(1'b1, 4'h9, 14'h0ABC, 32'hCAFE_F00D);
    begin_frame(); send_hdr(1'b1, 4'h9, 14'h0ABC);
    send_bits(32'hCAFE_F00D, 32, 1'b0, rd);
    end_frame();

    // Reset mid-header
    begin_frame();
    send_bits(32'hFF00_0000, 8, 1'b0, rd);
    rst_n = 1'b0;
    wait_clks(2);
    chk("mrst_code", {28'b0, memory_code}, 32'h0);
    chk("mrst_addr", {18'b0, spi_address}, 32'h0);
    chk("mrst_data", spi_data_in, 32'h0);
    chk("mrst_miso", {31'b0, spi_miso}, 32'h0);
    chk("mrst_pulses", {30'b0, program_memory_new, read_memory_sync}, 32'h0);
    spi_cs_n = 1'b1;
    wait_clks(2);
    rst_n = 1'b1;
    wait_clks(8);
    push(1'b1, 4'h7, 14'h0001, 32'h1234_5678);
    begin_frame(); send_hdr(1'b1, 4'h7, 14'h0001);
    send_bits(32'h1234_5678, 32, 1'b0, rd);
    end_frame();

    wait_clks(20);
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
